dmx8_32bits_seq: RTL and testbench

Registered 1-to-8 word distributor: the write-side counterpart of the 8:1 32-bit operand mux in the alu32 datapath. It accepts one 32-bit word per cycle and steers it into one of eight holding registers (a..h), either at an explicit 3-bit select (s2,s1,s0) or at an auto-incrementing pointer. It tracks which slots hold fresh data, flags when the bank is full, and releases the bank on a consumer handshake. Outputs a..h connect directly to the mux data inputs.

---
 rtl/alu32_pkg.sv | 16 +
 rtl/reg32_en.sv | 21 ++
 rtl/dmx8_32bits_seq.sv | 89 ++++++++
 tb/tb_dmx8_32bits_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu32_pkg.sv
// Shared constants for the alu32 datapath: slot count, select width and
// symbolic slot indices for the 8:1 operand mux and its write-side distributor.
package alu32_pkg;
    localparam int NUM_SLOTS     = 8;
    localparam int SEL_W         = 3;
    localparam int WIDTH_DEFAULT = 32;

    localparam int SLOT_A = 0;
    localparam int SLOT_B = 1;
    localparam int SLOT_C = 2;
    localparam int SLOT_D = 3;
    localparam int SLOT_E = 4;
    localparam int SLOT_F = 5;
    localparam int SLOT_G = 6;
    localparam int SLOT_H = 7;
endpackage

// File: rtl/reg32_en.sv
// WIDTH-bit holding register: async active-high reset, synchronous clear
// (dominant) and load enable.
module reg32_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/dmx8_32bits_seq.sv
// Registered 1-to-8 word distributor feeding the alu32 operand mux. Steers
// each written word to an explicit or auto-incremented slot and tracks fill.
module dmx8_32bits_seq
    import alu32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     d,
    input  logic                 wr_en,
    input  logic                 auto,
    input  logic                 s2,
    input  logic                 s1,
    input  logic                 s0,
    input  logic                 clr,
    input  logic                 rd,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     c,
    output logic [WIDTH-1:0]     d_o,
    output logic [WIDTH-1:0]     e,
    output logic [WIDTH-1:0]     f,
    output logic [WIDTH-1:0]     g,
    output logic [WIDTH-1:0]     h,
    output logic [NUM_SLOTS-1:0] valid,
    output logic                 full,
    output logic                 done,
    output logic [SEL_W-1:0]     ptr
);
    logic [SEL_W-1:0]                k;
    logic [NUM_SLOTS-1:0]            we;
    logic [NUM_SLOTS-1:0]            valid_nx;
    logic [SEL_W-1:0]                ptr_nx;
    logic                            rel;
    logic [NUM_SLOTS-1:0][WIDTH-1:0] slot;

    assign full = &valid;

    // Slot index uses the pre-release ptr, so a release+auto write lands in
    // the slot the pointer held (slot A after a full wrap) and ptr ends at 1.
    always_comb begin
        k        = auto ? ptr : {s2, s1, s0};
        we       = '0;
        if (wr_en)
            we[k] = 1'b1;
        rel      = rd & full;
        valid_nx = (rel ? '0 : valid) | we;
        ptr_nx   = rel ? SEL_W'(SLOT_A) : ptr;
        if (wr_en && auto)
            ptr_nx = ptr_nx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            ptr   <= '0;
            done  <= 1'b0;
        end else if (clr) begin
            valid <= '0;
            ptr   <= '0;
            done  <= 1'b0;
        end else begin
            valid <= valid_nx;
            ptr   <= ptr_nx;
            done  <= ~full & (&valid_nx);
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        reg32_en #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .en    (we[i]),
            .d     (d),
            .q     (slot[i])
        );
    end

    assign a   = slot[SLOT_A];
    assign b   = slot[SLOT_B];
    assign c   = slot[SLOT_C];
    assign d_o = slot[SLOT_D];
    assign e   = slot[SLOT_E];
    assign f   = slot[SLOT_F];
    assign g   = slot[SLOT_G];
    assign h   = slot[SLOT_H];
endmodule

// File: tb/tb_dmx8_32bits_seq.sv
// Scoreboard bench for dmx8_32bits_seq: directed test-plan sequences plus
// random traffic, each cycle's expected bank state queued and checked post-edge.
module tb_dmx8_32bits_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d;
    logic        wr_en, auto, s2, s1, s0, clr, rd;
    logic [31:0] a, b, c, d_o, e, f, g, h;
    logic [7:0]  valid;
    logic        full, done;
    logic [2:0]  ptr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] s [8];
        logic [7:0]  v;
        logic        fl;
        logic        dn;
        logic [2:0]  p;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_slot [8];
    bit          m_val  [8];
    int          m_ptr;

    always #5 clk = ~clk;

    dmx8_32bits_seq dut (
        .clk(clk), .reset(reset), .d(d), .wr_en(wr_en), .auto(auto),
        .s2(s2), .s1(s1), .s0(s0), .clr(clr), .rd(rd),
        .a(a), .b(b), .c(c), .d_o(d_o), .e(e), .f(f), .g(g), .h(h),
        .valid(valid), .full(full), .done(done), .ptr(ptr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < 8; i++)
            if (!m_val[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) begin
            m_slot[i] = '0;
            m_val[i]  = 1'b0;
        end
        m_ptr = 0;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the expected
    // post-edge state derived from the behavioural rules.
    task automatic step(input bit wr, input bit au, input int sel, input logic [31:0] data,
                        input bit r, input bit cl);
        int   k;
        bit   was_full;
        exp_t x;
        @(negedge clk);
        wr_en = wr; auto = au; {s2, s1, s0} = 3'(sel); d = data; rd = r; clr = cl;
        k = au ? m_ptr : sel;
        was_full = m_full();
        if (cl) begin
            m_reset();
        end else begin
            if (r && was_full) begin
                for (int i = 0; i < 8; i++) m_val[i] = 1'b0;
                m_ptr = 0;
            end
            if (wr) begin
                m_slot[k] = data;
                m_val[k]  = 1'b1;
                if (au) m_ptr = (m_ptr + 1) % 8;
            end
        end
        for (int i = 0; i < 8; i++) begin
            x.s[i]  = m_slot[i];
            x.v[i]  = m_val[i];
        end
        x.fl = m_full();
        x.dn = !cl && !was_full && x.fl;
        x.p  = 3'(m_ptr);
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("slot_a", a,   x.s[0]);
                chk("slot_b", b,   x.s[1]);
                chk("slot_c", c,   x.s[2]);
                chk("slot_d", d_o, x.s[3]);
                chk("slot_e", e,   x.s[4]);
                chk("slot_f", f,   x.s[5]);
                chk("slot_g", g,   x.s[6]);
                chk("slot_h", h,   x.s[7]);
                chk("valid",  32'(valid), 32'(x.v));
                chk("full",   32'(full),  32'(x.fl));
                chk("done",   32'(done),  32'(x.dn));
                chk("ptr",    32'(ptr),   32'(x.p));
            end
        end
    end

    initial begin : stim
        int budget;
        reset = 1'b1;
        wr_en = 0; auto = 0; {s2, s1, s0} = 3'b000; d = '0; rd = 0; clr = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset mid-fill, asserted away from any clock edge
        step(1, 1, 0, 32'h01020304, 0, 0);
        step(1, 1, 0, 32'h05060708, 0, 0);
        step(1, 1, 0, 32'h090a0b0c, 0, 0);
        @(negedge clk);
        wr_en = 0;
        #2 reset = 1'b1;
        #1;
        chk("rst_a", a, 32'h0);
        chk("rst_b", b, 32'h0);
        chk("rst_c", c, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ptr", 32'(ptr), 32'h0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;

        // auto fill 0x11111111..0x88888888, done pulses once, ptr wraps
        for (int i = 1; i <= 8; i++)
            step(1, 1, 0, 32'h11111111 * i, 0, 0);
        idle();
        idle();

        // release with simultaneous auto write
        step(1, 1, 0, 32'hCAFEF00D, 1, 0);
        idle();

        // refill to full, then clear beats write and release
        for (int i = 0; i < 7; i++)
            step(1, 1, 0, $urandom, 0, 0);
        idle();
        step(1, 1, 0, 32'h12345678, 1, 1);

        // explicit select 3'b101
        step(1, 0, 5, 32'hDEADBEEF, 0, 0);
        step(0, 0, 0, 32'h0, 0, 1);

        // ignored release with valid = 8'h0F
        for (int i = 0; i < 4; i++)
            step(1, 0, i, $urandom, 0, 0);
        step(0, 0, 0, 32'h0, 1, 0);
        idle();

        // random traffic
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 7),
                 $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
